// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - fetch/data arbiter for one shared variable-latency memory
// Define MEM_ARB_FAIRNESS_EN to force a fetch grant after STARVE_LIMIT data grants.
module unified_mem_arbiter #(
  parameter int TIMEOUT      = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_funct3,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_funct3,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      r_state;
  logic [31:0] r_tcnt;
  logic        w_idle;
  logic        w_force_if;
  logic        w_timeout;

  // Grants stay low while reset is asserted even though the state reads IDLE.
  assign w_idle    = rst_n && (r_state == IDLE);
  assign w_timeout = (TIMEOUT != 0) && (r_tcnt == 32'(TIMEOUT - 1));

`ifdef MEM_ARB_FAIRNESS_EN
  logic [31:0] r_starve;

  assign w_force_if = if_req && (r_starve == 32'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (if_gnt) begin
      r_starve <= '0;
    end else if (dm_gnt && if_req) begin
      r_starve <= r_starve + 32'd1;
    end
  end
`else
  assign w_force_if = (STARVE_LIMIT < 0) && if_req;
`endif

  assign dm_gnt = w_idle && dm_req && !w_force_if;
  assign if_gnt = w_idle && if_req && (!dm_req || w_force_if);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tcnt     <= '0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      dm_rvalid  <= 1'b0;
      dm_rdata   <= '0;
      dm_err     <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_funct3 <= '0;
    end else begin
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      dm_rvalid <= 1'b0;
      dm_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tcnt <= '0;
          if (dm_gnt) begin
            r_state    <= WAIT_D;
            mem_req    <= 1'b1;
            mem_we     <= dm_we;
            mem_addr   <= dm_addr;
            mem_wdata  <= dm_wdata;
            mem_funct3 <= dm_funct3;
          end else if (if_gnt) begin
            r_state    <= WAIT_I;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr & ~32'h3;
            mem_wdata  <= '0;
            mem_funct3 <= 3'b010;
          end
        end
        WAIT_I, WAIT_D: begin
          // An ack in the last allowed cycle still completes normally.
          if (mem_ack || w_timeout) begin
            r_state <= IDLE;
            mem_req <= 1'b0;
            if (r_state == WAIT_I) begin
              if_rvalid <= 1'b1;
              if_err    <= !mem_ack;
              if_rdata  <= mem_ack ? mem_rdata : NOP;
            end else begin
              dm_rvalid <= 1'b1;
              dm_err    <= !mem_ack;
              if (!mem_ack) begin
                dm_rdata <= '0;
              end else if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
            end
          end else begin
            r_tcnt <= r_tcnt + 32'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed bench for unified_mem_arbiter (TIMEOUT=8, STARVE_LIMIT=4)
module tb_unified_mem_arbiter;
  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [2:0]  dm_funct3;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dm_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    int          delay;
    logic [31:0] mrdata;
    logic [31:0] exp_maddr;
    logic [31:0] exp_rdata;
  } txn_t;

  unified_mem_arbiter #(.TIMEOUT(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_funct3(dm_funct3), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic run_txn(input txn_t t);
    if (t.is_dm) begin
      dm_req = 1'b1; dm_we = t.we; dm_addr = t.addr; dm_wdata = t.wdata; dm_funct3 = t.f3;
    end else begin
      if_req = 1'b1; if_addr = t.addr;
    end
    #1;
    chk("gnt", t.is_dm ? dm_gnt : if_gnt, 1);
    chk("other_gnt", t.is_dm ? if_gnt : dm_gnt, 0);
    cyc();
    dm_req = 1'b0;
    if_req = 1'b0;
    for (int k = 0; k <= t.delay; k++) begin
      if (k == t.delay) begin
        mem_ack = 1'b1;
        mem_rdata = t.mrdata;
      end
      #1;
      chk("mem_req", mem_req, 1);
      chk("mem_addr", mem_addr, t.exp_maddr);
      chk("mem_we", mem_we, t.is_dm ? t.we : 1'b0);
      chk("mem_funct3", mem_funct3, t.is_dm ? t.f3 : 3'b010);
      if (t.is_dm && t.we) chk("mem_wdata", mem_wdata, t.wdata);
      chk("early_rvalid", if_rvalid | dm_rvalid, 0);
      cyc();
    end
    mem_ack = 1'b0;
    mem_rdata = 32'h0BAD_0BAD;
    #1;
    chk("rvalid", t.is_dm ? dm_rvalid : if_rvalid, 1);
    chk("err", t.is_dm ? dm_err : if_err, 0);
    chk("rdata", t.is_dm ? dm_rdata : if_rdata, t.exp_rdata);
    chk("mem_req_drop", mem_req, 0);
    cyc();
    #1;
    chk("rvalid_pulse", if_rvalid | dm_rvalid, 0);
    chk("rdata_hold", t.is_dm ? dm_rdata : if_rdata, t.exp_rdata);
  endtask

  initial begin
    txn_t tbl[6];
    txn_t t;
    int   n_gnt;

    tbl[0] = '{1'b0, 1'b0, 32'h0000_0406, 32'h0, 3'b000, 0, 32'h00A0_0093, 32'h0000_0404, 32'h00A0_0093};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 3'b010, 1, 32'hCAFE_F00D, 32'h0000_0100, 32'hCAFE_F00D};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 3'b000, 3, 32'hFFFF_FFFF, 32'h0000_0020, 32'hCAFE_F00D};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_0103, 32'h0, 3'b100, 2, 32'h0000_0080, 32'h0000_0103, 32'h0000_0080};
    tbl[4] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 3'b000, 5, 32'h1234_5013, 32'hFFFF_FFFC, 32'h1234_5013};
    tbl[5] = '{1'b1, 1'b1, 32'h7FFF_FFF1, 32'hA5A5_5A5A, 3'b001, 7, 32'hFFFF_FFFF, 32'h7FFF_FFF1, 32'h0000_0080};

    rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0406;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h1; dm_funct3 = 3'b010;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) cyc();
    #1;
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_dm_gnt", dm_gnt, 0);
    chk("rst_rvalid", {if_rvalid, dm_rvalid, if_err, dm_err}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_mem_ctl", {mem_req, mem_we, mem_funct3}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    dm_req = 1'b0;
    dm_we = 1'b0;

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    // Conflict: data wins, fetch is granted in the cycle carrying dm_rvalid.
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; dm_funct3 = 3'b010;
    #1;
    chk("cf_dm_gnt", dm_gnt, 1);
    chk("cf_if_gnt", if_gnt, 0);
    cyc();
    dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("cf_mem_addr", mem_addr, 32'h100);
    cyc();
    mem_ack = 1'b0;
    #1;
    chk("cf_dm_rvalid", dm_rvalid, 1);
    chk("cf_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
    chk("cf_if_gnt2", if_gnt, 1);
    t = '{1'b0, 1'b0, 32'h200, 32'h0, 3'b000, 0, 32'h0000_0013, 32'h200, 32'h0000_0013};
    run_txn(t);

    // Both requests held with instant ack.
    if_req = 1'b1; if_addr = 32'h500;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600; dm_funct3 = 3'b010;
    mem_ack = 1'b1; mem_rdata = 32'h0;
    n_gnt = 0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (if_gnt || dm_gnt) begin
`ifdef MEM_ARB_FAIRNESS_EN
        chk("fair_if_gnt", if_gnt, (n_gnt % 5) == 4);
`else
        chk("strict_if_gnt", if_gnt, 0);
`endif
        n_gnt++;
      end
      cyc();
    end
    chk("grant_count", n_gnt, 25);
    if_req = 1'b0; dm_req = 1'b0;
    cyc();
    mem_ack = 1'b0;
    cyc();

    // Fetch timeout, then a stray ack in IDLE.
    if_req = 1'b1; if_addr = 32'h300;
    #1;
    chk("to_if_gnt", if_gnt, 1);
    cyc();
    if_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("to_mem_req", mem_req, 1);
      cyc();
    end
    #1;
    chk("to_mem_req_drop", mem_req, 0);
    chk("to_if_rvalid", if_rvalid, 1);
    chk("to_if_err", if_err, 1);
    chk("to_if_rdata", if_rdata, 32'h0000_0013);
    cyc();
    #1;
    chk("to_err_clear", {if_rvalid, if_err}, 0);
    mem_ack = 1'b1;
    cyc();
    cyc();
    mem_ack = 1'b0;
    #1;
    chk("stray_ack", {if_rvalid, dm_rvalid, mem_req}, 0);

    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80; dm_funct3 = 3'b010;
    #1;
    chk("dto_gnt", dm_gnt, 1);
    cyc();
    dm_req = 1'b0;
    repeat (8) cyc();
    #1;
    chk("dto_rvalid_err", {dm_rvalid, dm_err, mem_req}, 3'b110);
    chk("dto_rdata", dm_rdata, 0);
    cyc();

    // Asynchronous reset during WAIT_D, late ack afterwards.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; dm_funct3 = 3'b010;
    #1;
    chk("mr_gnt", dm_gnt, 1);
    cyc();
    dm_req = 1'b0;
    #1;
    chk("mr_mem_req", mem_req, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_async_drop", mem_req, 0);
    #1 rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    cyc();
    #1;
    chk("mr_no_rvalid1", dm_rvalid, 0);
    cyc();
    #1;
    chk("mr_no_rvalid2", dm_rvalid, 0);
    mem_ack = 1'b0;
    t = '{1'b1, 1'b0, 32'h44, 32'h0, 3'b010, 0, 32'h0000_0055, 32'h44, 32'h0000_0055};
    run_txn(t);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
